// File: rtl/joybus_tx.sv
// joybus_tx: console-side Joybus transmitter.
// Serializes up to MAX_BITS command bits (MSB first) onto the open-drain
// Joybus line, appends the console stop bit, then pulses tx_done in the
// same cycle the line is released so a receiver can start immediately.
//
// Ports:
//   clk           system clock
//   rst           synchronous active-high reset
//   tx_start      one-cycle frame request, honoured only when idle
//   tx_data       left-justified command, bit [MAX_BITS-1] sent first
//   tx_len        number of command bits, clamped to MAX_BITS
//   jb_drive_low  1 = pull line low, 0 = release (registered)
//   tx_busy       high while a frame is in progress (state != IDLE)
//   tx_done       one-cycle pulse after the stop bit (registered)
//
// state    | meaning
// IDLE     | line released, waiting for tx_start
// BIT_LOW  | low phase of a data bit (T for '1', 3T for '0')
// BIT_HIGH | high phase of a data bit (3T for '1', T for '0')
// STOP_LOW | console stop bit, T low
// DONE     | line released, tx_done high for one cycle
module joybus_tx #(
  parameter int CLK_PER_US = 25,
  parameter int MAX_BITS   = 24
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tx_start,
  input  logic [MAX_BITS-1:0] tx_data,
  input  logic [4:0]          tx_len,
  output logic                jb_drive_low,
  output logic                tx_busy,
  output logic                tx_done
);

  localparam int CW = $clog2(4 * CLK_PER_US + 1);
  localparam logic [CW-1:0] T1      = CW'(CLK_PER_US);
  localparam logic [CW-1:0] T3      = CW'(3 * CLK_PER_US);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [4:0]    MAX_LEN = 5'(MAX_BITS);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    BIT_LOW  = 3'd1,
    BIT_HIGH = 3'd2,
    STOP_LOW = 3'd3,
    DONE     = 3'd4
  } state_t;

  state_t              state;
  logic [MAX_BITS-1:0] sr;
  logic [4:0]          bits_left;
  logic [CW-1:0]       cnt;

  logic [4:0]          len_clamped;
  logic [MAX_BITS-1:0] sr_shifted;

  assign len_clamped = (tx_len > MAX_LEN) ? MAX_LEN : tx_len;
  // Next MSB after the shift decides the low length of the following bit.
  assign sr_shifted  = sr << 1;
  assign tx_busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      sr           <= '0;
      bits_left    <= '0;
      cnt          <= '0;
      jb_drive_low <= 1'b0;
      tx_done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          jb_drive_low <= 1'b0;
          tx_done      <= 1'b0;
          if (tx_start) begin
            sr           <= tx_data;
            bits_left    <= len_clamped;
            jb_drive_low <= 1'b1;
            if (len_clamped != 5'd0) begin
              state <= BIT_LOW;
              cnt   <= tx_data[MAX_BITS-1] ? T1 : T3;
            end else begin
              state <= STOP_LOW;
              cnt   <= T1;
            end
          end
        end
        BIT_LOW: begin
          cnt <= cnt - CNT_ONE;
          if (cnt == CNT_ONE) begin
            state        <= BIT_HIGH;
            cnt          <= sr[MAX_BITS-1] ? T3 : T1;
            jb_drive_low <= 1'b0;
          end
        end
        BIT_HIGH: begin
          cnt <= cnt - CNT_ONE;
          if (cnt == CNT_ONE) begin
            sr           <= sr_shifted;
            bits_left    <= bits_left - 5'd1;
            jb_drive_low <= 1'b1;
            if (bits_left == 5'd1) begin
              state <= STOP_LOW;
              cnt   <= T1;
            end else begin
              state <= BIT_LOW;
              cnt   <= sr_shifted[MAX_BITS-1] ? T1 : T3;
            end
          end
        end
        STOP_LOW: begin
          cnt <= cnt - CNT_ONE;
          if (cnt == CNT_ONE) begin
            state        <= DONE;
            cnt          <= '0;
            jb_drive_low <= 1'b0;
            tx_done      <= 1'b1;
          end
        end
        DONE: begin
          state   <= IDLE;
          tx_done <= 1'b0;
        end
        default: begin
          state        <= IDLE;
          jb_drive_low <= 1'b0;
          tx_done      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_joybus_tx.sv
module tb_joybus_tx;

  localparam int T = 25;

  logic        clk = 1'b0;
  logic        rst;
  logic        tx_start;
  logic [23:0] tx_data;
  logic [4:0]  tx_len;
  logic        jb_drive_low;
  logic        tx_busy;
  logic        tx_done;

  int checks = 0;
  int errors = 0;

  // Expected per-cycle outputs {drive, done, busy}; empty queue means idle.
  logic [2:0] exp_q[$];
  logic       chk_en = 1'b0;

  // Line observation for decoding and latency measurement.
  int runs[$];
  int run = 0;
  int lat_cnt = -1;
  int lat_meas = -1;
  int done_cnt = 0;

  joybus_tx #(.CLK_PER_US(T), .MAX_BITS(24)) dut (
    .clk(clk),
    .rst(rst),
    .tx_start(tx_start),
    .tx_data(tx_data),
    .tx_len(tx_len),
    .jb_drive_low(jb_drive_low),
    .tx_busy(tx_busy),
    .tx_done(tx_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Waveform model: each bit is 4T cycles, '1' = T low, '0' = 3T low;
  // stop bit T low; then one released cycle with tx_done.
  task automatic push_frame(input logic [23:0] d, input int n);
    for (int i = 0; i < n; i++) begin
      int low;
      low = d[23 - i] ? T : 3 * T;
      for (int k = 0; k < low; k++) exp_q.push_back(3'b101);
      for (int k = 0; k < 4 * T - low; k++) exp_q.push_back(3'b001);
    end
    for (int k = 0; k < T; k++) exp_q.push_back(3'b101);
    exp_q.push_back(3'b011);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      logic [2:0] e;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 3'b000;
      chk("jb_drive_low", {31'd0, jb_drive_low}, {31'd0, e[2]});
      chk("tx_done",      {31'd0, tx_done},      {31'd0, e[1]});
      chk("tx_busy",      {31'd0, tx_busy},      {31'd0, e[0]});
      if (jb_drive_low === 1'b1) run++;
      else if (run > 0) begin
        runs.push_back(run);
        run = 0;
      end
      if (lat_cnt >= 0) lat_cnt++;
      if (tx_done === 1'b1) begin
        done_cnt++;
        lat_meas = lat_cnt;
      end
    end
  end

  // poke: cycle at which a stray tx_start (with different data) is pulsed.
  // rst_at: cycle at which reset is asserted mid-frame (no tx_done expected).
  task automatic send(input logic [23:0] d, input logic [4:0] len, input int poke,
                      input int rst_at, input int exp_lat, input logic [23:0] exp_word);
    int n;
    logic got;
    logic [23:0] word;
    n = (len > 5'd24) ? 24 : int'(len);
    tx_data  = d;
    tx_len   = len;
    tx_start = 1'b1;
    @(posedge clk);
    #1;
    tx_start = 1'b0;
    push_frame(d, n);
    lat_cnt  = 0;
    lat_meas = -1;
    done_cnt = 0;
    run      = 0;
    runs.delete();
    got = 1'b0;
    for (int cyc = 0; cyc < 4000 && !got; cyc++) begin
      @(posedge clk);
      #1;
      tx_start = (cyc == poke);
      if (cyc == poke) begin
        tx_data = ~d;
        tx_len  = 5'd3;
      end
      if (cyc == rst_at) begin
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        lat_cnt = -1;
        repeat (20) @(posedge clk);
        #1;
        chk("no_done_after_rst", done_cnt, 0);
        return;
      end
      got = (done_cnt > 0);
    end
    lat_cnt = -1;
    chk("done_timeout", {31'd0, got}, 32'd1);
    chk("done_latency", lat_meas, exp_lat);
    chk("done_count", done_cnt, 1);
    chk("low_runs", runs.size(), n + 1);
    if (runs.size() == n + 1) begin
      word = '0;
      for (int i = 0; i < n; i++) word = {word[22:0], (runs[i] < 2 * T)};
      if (n < 24) word = word << (24 - n);
      chk("decoded_word", word, exp_word);
      chk("stop_low_len", runs[n], T);
    end
  endtask

  initial begin
    rst      = 1'b1;
    tx_start = 1'b1;
    tx_data  = 24'hFFFFFF;
    tx_len   = 5'd24;
    @(posedge clk);
    #1;
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst      = 1'b0;
    tx_start = 1'b0;
    repeat (10) @(posedge clk);
    #1;

    // single '0'
    send(24'h000000, 5'd1, -1, -1, 126, 24'h000000);
    repeat (3) @(posedge clk);
    #1;
    // GC poll
    send(24'h400300, 5'd24, -1, -1, 2426, 24'h400300);
    // status command with stray tx_start during bit 3
    send(24'h000000, 5'd8, 2 * 4 * T + 30, -1, 8 * 4 * T + T + 1, 24'h000000);
    // reset while bit 5 is low (bit 5 of 0x400300 is '0')
    send(24'h400300, 5'd24, -1, 4 * 4 * T + 10, 0, 24'h0);
    // new frame accepted after reset; tx_len=0 sends only the stop bit
    send(24'hFFFFFF, 5'd0, -1, -1, 26, 24'h000000);
    // tx_len=31 clamps to 24
    send(24'hA5C3F0, 5'd31, -1, -1, 2426, 24'hA5C3F0);
    repeat (5) @(posedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/joybus_tx.md
# joybus_tx

Console-side Joybus transmitter. Serializes a command of up to 24 bits (MSB first) onto the single-wire Joybus line, then appends the console stop bit. When the stop bit is complete it pulses `tx_done`, so the top level can start the receiver in the same cycle and catch the controller's reply. The block drives the shared open-drain line: it only ever pulls the line low or releases it.

## Interface
- `CLK_PER_US`, default 25: clock cycles per microsecond; one bit period is 4·CLK_PER_US cycles (100 at 25 MHz).
- `MAX_BITS`, default 24: width of the command register.

- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `tx_start`  in  1  one-cycle request; sampled only in IDLE.
- `tx_data`  in  MAX_BITS  command, left-justified; bit [MAX_BITS-1] is sent first.
- `tx_len`  in  5  number of command bits (0..MAX_BITS); values > MAX_BITS are clamped to MAX_BITS.
- `jb_drive_low`  out  1  1 = pull line low (open-drain enable), 0 = release. Registered.
- `tx_busy`  out  1  high from the cycle after an accepted `tx_start` through the cycle `tx_done` is high.
- `tx_done`  out  1  one-cycle pulse after the stop bit's low phase ends. Registered.

## Operation
- Bit encoding, with T = CLK_PER_US:
  - '0' = 3T cycles low, then 1T high.
  - '1' = 1T low, then 3T high.
  - Stop bit = 1T low, then release.
- Datapath registers:
  - Shift register `sr` [MAX_BITS-1:0], loaded from `tx_data` on accept; shifts left by one at the end of each bit.
  - Bit counter `bits_left` [4:0], loaded with the clamped `tx_len`.
  - Phase counter `cnt`, width $clog2(4T+1), reloaded at each phase start and decremented to 1.
- State machine states: IDLE, BIT_LOW, BIT_HIGH, STOP_LOW, DONE.
  - IDLE: line released. On `tx_start`, load `sr` and `bits_left`.
    - Next state is BIT_LOW if `bits_left` is nonzero, else STOP_LOW.
    - `cnt` loads with the low length for `sr` MSB (T or 3T), or T for STOP_LOW.
  - BIT_LOW: `jb_drive_low`=1. When `cnt`==1, go to BIT_HIGH and load `cnt` with the high length (3T for '1', T for '0').
  - BIT_HIGH: `jb_drive_low`=0. When `cnt`==1:
    - Shift `sr` and decrement `bits_left`.
    - If `bits_left` was 1, go to STOP_LOW with `cnt`=T.
    - Otherwise go to BIT_LOW with `cnt` set from the new MSB.
  - STOP_LOW: `jb_drive_low`=1. When `cnt`==1, go to DONE.
  - DONE: `jb_drive_low`=0, `tx_done`=1 for exactly this one cycle, then IDLE.
- `tx_start` outside IDLE is ignored, with no queuing; `tx_data`/`tx_len` changes mid-frame have no effect.
- Simultaneous `rst` and `tx_start`: reset wins; the frame is not accepted.

## Timing
- Reset values: `jb_drive_low`=0, `tx_done`=0, `tx_busy`=0, state IDLE, `sr`=0, `bits_left`=0, `cnt`=0.
- Reset mid-frame: on the next edge the line is released and state returns to IDLE. `tx_done` is not pulsed.
- `tx_start` accepted at edge E:
  - `jb_drive_low` rises at E+1; the first bit starts there.
  - Each bit is exactly 4T cycles; phase boundaries contain no idle or extra cycles.
- Frame length for N = clamped `tx_len`:
  - Line activity spans N·4T + T cycles.
  - `tx_done` is high in cycle E+1+N·4T+T.
  - The block is back in IDLE and can accept a new `tx_start` one cycle after that.
- `tx_done` and the line release happen in the same cycle, so the receiver can start in that cycle. The controller reply begins at least 2 µs later.
- `tx_busy` is derived from state (state != IDLE), combinational from the registered state.

## Test plan
- Reset: hold `rst` 3 cycles with `tx_start`=1. Required: `jb_drive_low`=0, `tx_busy`=0, `tx_done`=0 throughout, and no frame afterwards.
- Single '0' (`tx_len`=1, `tx_data`[23]=0, T=25):
  - 75 cycles low, 25 high, 25 low (stop).
  - `tx_done` pulses exactly 126 cycles after the accept edge.
- GC poll (`tx_data`=0x400300, `tx_len`=24):
  - Decoding the low widths gives 25 for '1' and 75 for '0', reproducing 0x400300.
  - `tx_done` arrives at 2426 cycles after accept.
- Status command (`tx_data`=0x000000, `tx_len`=8):
  - Eight bits of 75 low / 25 high, then stop.
  - `tx_start` re-pulsed during bit 3 is ignored: the frame is unchanged and there is a single `tx_done`.
- Assert `rst` during bit 5 while the line is low. Required: line released on the next edge, no `tx_done`, and a new `tx_start` is accepted normally.
- `tx_len` boundaries:
  - `tx_len`=0: only the 25-cycle stop bit is sent; `tx_done` at 26.
  - `tx_len`=31: clamped to 24 bits; `tx_done` at 2426.
